// File: rtl/codec_pkg.sv
// codec_pkg: shared types and helpers for the priority encoder / one-hot pulse decoder pair
package codec_pkg;
  localparam int IDX_W_DEF = 2;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  function automatic int n_out(input int idx_w);
    return 1 << idx_w;
  endfunction
endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down counter that saturates at 1 (never wraps)
module load_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_one
);
  assign is_one = value == W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clr) value <= '0;
    else if (load) value <= load_val;
    else if (dec && value > W'(1)) value <= value - W'(1);
endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: turns an accepted channel index into a timed one-hot pulse
// followed by a fixed quiet gap; all outputs come straight from flops.
module onehot_pulse_decoder
  import codec_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 1,
  localparam int N_OUT     = n_out(IDX_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [LEN_W-1:0] in_len,
  input  logic             flush,
  output logic [N_OUT-1:0] out_onehot,
  output logic             busy,
  output logic             done
);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  state_t state, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [LEN_W-1:0] len_eff, drv_val, drv_next;
  logic [GW-1:0] gap_val;
  logic ready_q, accept, drv_one, gap_one;
  logic drv_ld, drv_dec, gap_ld, gap_dec;
  assign in_ready = ready_q & ~flush;
  assign accept   = in_valid & in_ready;
  assign len_eff  = in_len == '0 ? LEN_W'(1) : in_len;
  assign idx_n    = accept ? in_idx : idx_q;
  load_down_counter #(.W(LEN_W)) u_drv (
    .clk(clk), .rst_n(rst_n), .clr(flush), .load(drv_ld), .load_val(len_eff),
    .dec(drv_dec), .value(drv_val), .is_one(drv_one)
  );
  load_down_counter #(.W(GW)) u_gap (
    .clk(clk), .rst_n(rst_n), .clr(flush), .load(gap_ld), .load_val(GW'(GAP_CYCLES)),
    .dec(gap_dec), .value(gap_val), .is_one(gap_one)
  );
  always_comb begin
    state_n = state;
    drv_ld  = 1'b0;
    drv_dec = 1'b0;
    gap_ld  = 1'b0;
    gap_dec = 1'b0;
    if (flush) state_n = IDLE;
    else
      unique case (state)
        IDLE: begin
          drv_ld  = accept;
          state_n = accept ? DRIVE : IDLE;
        end
        DRIVE: begin
          gap_ld  = drv_one && GAP_CYCLES > 0;
          drv_dec = !drv_one;
          state_n = !drv_one ? DRIVE : GAP_CYCLES > 0 ? GAP : IDLE;
        end
        GAP: begin
          gap_dec = !gap_one;
          // a zero gap count can only come from corruption; leave rather than stall
          state_n = (gap_one || gap_val == '0) ? IDLE : GAP;
        end
        default: state_n = IDLE;
      endcase
  end
  assign drv_next = flush ? '0 : drv_ld ? len_eff : (drv_dec && drv_val > LEN_W'(1)) ? drv_val - LEN_W'(1) : drv_val;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      idx_q      <= '0;
      ready_q    <= 1'b1;
      out_onehot <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      idx_q      <= idx_n;
      ready_q    <= state_n == IDLE;
      out_onehot <= state_n == DRIVE ? N_OUT'(1) << idx_n : '0;
      busy       <= state_n != IDLE;
      done       <= state_n == DRIVE && drv_next == LEN_W'(1);
    end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: directed checks of pulse timing, handshake, flush and async reset
module tb_onehot_pulse_decoder;
  logic clk = 1'b0, rst_n = 1'b1;
  logic v1 = 0, fl1 = 0, v0 = 0, fl0 = 0;
  logic [1:0] idx1 = 0, idx0 = 0;
  logic [3:0] len1 = 0, len0 = 0;
  logic rdy1, busy1, done1, rdy0, busy0, done0;
  logic [3:0] oh1, oh0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  onehot_pulse_decoder #(.IDX_W(2), .LEN_W(4), .GAP_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_idx(idx1), .in_len(len1),
    .flush(fl1), .out_onehot(oh1), .busy(busy1), .done(done1)
  );
  onehot_pulse_decoder #(.IDX_W(2), .LEN_W(4), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_idx(idx0), .in_len(len0),
    .flush(fl0), .out_onehot(oh0), .busy(busy0), .done(done0)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic st1(input string tag, input logic [3:0] oh, input logic d, input logic b, input logic r);
    chk({tag, ".oh"}, 32'(oh1), 32'(oh));
    chk({tag, ".done"}, 32'(done1), 32'(d));
    chk({tag, ".busy"}, 32'(busy1), 32'(b));
    chk({tag, ".rdy"}, 32'(rdy1), 32'(r));
  endtask
  task automatic st0(input string tag, input logic [3:0] oh, input logic d, input logic b, input logic r);
    chk({tag, ".oh"}, 32'(oh0), 32'(oh));
    chk({tag, ".done"}, 32'(done0), 32'(d));
    chk({tag, ".busy"}, 32'(busy0), 32'(b));
    chk({tag, ".rdy"}, 32'(rdy0), 32'(r));
  endtask
  initial begin
    #3 rst_n = 1'b0;
    @(negedge clk);
    st1("rst", 4'b0000, 0, 0, 1);
    st0("rst0", 4'b0000, 0, 0, 1);
    rst_n = 1'b1;
    @(negedge clk);
    v1 = 1; idx1 = 2; len1 = 3;
    @(negedge clk); st1("basic_d1", 4'b0100, 0, 1, 0); v1 = 0;
    @(negedge clk); st1("basic_d2", 4'b0100, 0, 1, 0);
    @(negedge clk); st1("basic_d3", 4'b0100, 1, 1, 0);
    @(negedge clk); st1("basic_gap", 4'b0000, 0, 1, 0);
    @(negedge clk); st1("basic_idle", 4'b0000, 0, 0, 1);
    v1 = 1; idx1 = 0; len1 = 0;
    @(negedge clk); st1("zero_d1", 4'b0001, 1, 1, 0); v1 = 0;
    @(negedge clk); st1("zero_gap", 4'b0000, 0, 1, 0);
    @(negedge clk); st1("zero_idle", 4'b0000, 0, 0, 1);
    v1 = 1; idx1 = 1; len1 = 2;
    @(negedge clk); st1("hs_d1", 4'b0010, 0, 1, 0); idx1 = 3;
    @(negedge clk); st1("hs_d2", 4'b0010, 1, 1, 0); idx1 = 0; len1 = 1;
    @(negedge clk); st1("hs_gap", 4'b0000, 0, 1, 0); idx1 = 2; len1 = 1;
    @(negedge clk); st1("hs_idle", 4'b0000, 0, 0, 1);
    @(negedge clk); st1("hs_acc", 4'b0100, 1, 1, 0); v1 = 0;
    @(negedge clk); st1("hs_gap2", 4'b0000, 0, 1, 0);
    @(negedge clk); st1("hs_idle2", 4'b0000, 0, 0, 1);
    v1 = 1; idx1 = 1; len1 = 8;
    @(negedge clk); st1("fl_d1", 4'b0010, 0, 1, 0); v1 = 0;
    @(negedge clk); st1("fl_d2", 4'b0010, 0, 1, 0);
    @(negedge clk); st1("fl_d3", 4'b0010, 0, 1, 0); fl1 = 1;
    @(negedge clk); st1("fl_abort", 4'b0000, 0, 0, 0); v1 = 1; idx1 = 3; len1 = 1;
    @(negedge clk); st1("fl_noacc", 4'b0000, 0, 0, 0); fl1 = 0; v1 = 0;
    #1 chk("fl_rdy_after", 32'(rdy1), 32'd1);
    @(negedge clk);
    v1 = 1; idx1 = 3; len1 = 4;
    @(negedge clk); st1("ar_d1", 4'b1000, 0, 1, 0); v1 = 0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("ar_oh", 32'(oh1), 32'h0);
    chk("ar_busy", 32'(busy1), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); st1("ar_idle", 4'b0000, 0, 0, 1);
    v1 = 1; idx1 = 1; len1 = 1;
    @(negedge clk); st1("ar_acc", 4'b0010, 1, 1, 0); v1 = 0;
    v0 = 1; idx0 = 3; len0 = 2;
    @(negedge clk); st0("b2b_d1", 4'b1000, 0, 1, 0); idx0 = 1; len0 = 1;
    @(negedge clk); st0("b2b_d2", 4'b1000, 1, 1, 0);
    @(negedge clk); st0("b2b_idle", 4'b0000, 0, 0, 1);
    @(negedge clk); st0("b2b_d3", 4'b0010, 1, 1, 0); v0 = 0;
    @(negedge clk); st0("b2b_end", 4'b0000, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onehot_pulse_decoder.md
# onehot_pulse_decoder

Sequential counterpart of the 4-input priority encoder: accepts an encoded 2-bit channel index over a valid/ready handshake and drives the matching one-hot output line for a requested number of cycles. A programmable quiet gap follows each pulse. The block sits downstream of the encoder in the select/grant path, turning compact indices back into timed per-channel enables.

## Interface
- IDX_W, 2, width of encoded index; N_OUT = 2**IDX_W is derived (localparam, 4 by default)
- LEN_W, 4, width of per-transaction pulse length
- GAP_CYCLES, 1, forced all-zero cycles after each pulse (0 allowed)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  index/length presented
- in_ready  out  1  block can accept a transaction
- in_idx  in  IDX_W  encoded channel index
- in_len  in  LEN_W  pulse length in cycles; 0 treated as 1
- flush  in  1  synchronous abort of current transaction
- out_onehot  out  N_OUT  registered one-hot drive, bit in_idx set
- busy  out  1  high in DRIVE or GAP
- done  out  1  one-cycle pulse on last DRIVE cycle

## Operation
- FSM states: IDLE, DRIVE, GAP.
- IDLE: in_ready=1, out_onehot=0. When in_valid&in_ready is sampled, latch in_idx, load cnt=max(in_len,1), go to DRIVE.
- DRIVE: out_onehot = 1<<idx_q, in_ready=0. cnt decrements each cycle. When cnt==1, done=1 this cycle. Next state is GAP if GAP_CYCLES>0 (gap counter loaded), else IDLE.
- GAP: out_onehot=0, in_ready=0. Count GAP_CYCLES cycles, then IDLE.
- flush (priority over everything except reset): next state IDLE, out_onehot=0 next cycle, counters cleared, no done. A transaction offered in the same cycle as flush is not accepted; in_ready is forced 0 while flush=1.
- in_idx/in_len are ignored outside the accept cycle. Changing them mid-pulse has no effect.
- out_onehot is always zero or exactly one-hot; never multi-hot.
- Counter widths: DRIVE counter LEN_W bits; gap counter clog2(GAP_CYCLES+1) bits (min 1). No wrap: counters only load and decrement to 1.

## Timing
- Reset (async assert, sync release at clk): state=IDLE, out_onehot=0, in_ready=1, busy=0, done=0, counters=0.
- Reset asserted mid-pulse clears outputs immediately (asynchronously), without waiting for clk.
- Accept at edge k: out_onehot set after edge k, held for L=max(in_len,1) cycles, cleared after edge k+L.
- done high in the cycle between edges k+L-1 and k+L.
- in_ready returns high after edge k+L+GAP_CYCLES. Earliest next accept is at edge k+L+GAP_CYCLES+1 (IDLE always lasts at least one cycle).
- Throughput: one transaction per L+GAP_CYCLES+1 cycles.
- busy = (state != IDLE). It is registered, aligned with out_onehot/gap.

## Structure
- Shared package codec_pkg holds:
  - state enum (IDLE/DRIVE/GAP)
  - IDX_W default
  - N_OUT derivation function, shared with the priority encoder
- One natural sub-module: load_down_counter (load, dec, value, is_one). It is instantiated twice, for the drive and gap counters.
- All outputs are registered. No combinational path from inputs to out_onehot.

## Test plan
- Reset/basic: release reset, idx=2, len=3 → out_onehot=0100 for 3 cycles; done on 3rd; then 0000 for 1 gap cycle; in_ready high after that gap cycle.
- Zero length: idx=0, len=0 → out_onehot=0001 for exactly 1 cycle, done coincident with it.
- Back-to-back, GAP_CYCLES=0: in_valid held high with idx=3/len=2, then idx=1/len=1 → 1000,1000,0000(IDLE),0010; no multi-hot cycle.
- Handshake: in_valid high while busy with idx changing → no accept and no output change until in_ready=1; then the value present at that accept edge is taken.
- Flush: accept idx=1, len=8; assert flush on 3rd drive cycle → out_onehot=0000 next cycle, no done, in_ready=1 the cycle after flush deasserts.
- Async reset mid-pulse: rst_n low between edges during DRIVE → out_onehot=0000 and busy=0 before the next edge; normal accept after release.
